cpu_clken_gen: RTL and testbench

//  Generates all clock enables for the Spectrum core from the single 56 MHz master clock.

---
 rtl/cpu_clken_gen.sv | 106 ++++++++++
 tb/tb_cpu_clken_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clken_gen.sv
// Clock-enable generator for the Spectrum core: one phase counter on the 56 MHz master clock
// feeds fixed 7/3.5 MHz enables and a speed-selectable CPU enable with ULA contention.
module cpu_clken_gen #(
    parameter int DIV_BITS  = 4,
    parameter int MAX_SPEED = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             power,
    input  logic [1:0]       speed,
    input  logic             vcn,
    input  logic             mreq,
    input  logic             ioula,
    input  logic             mcont,
    input  logic             cnt_clr,
    output logic             pe7M0,
    output logic             ne7M0,
    output logic             pe3M5,
    output logic             ne3M5,
    output logic             pcpu,
    output logic             ncpu,
    output logic             contend,
    output logic [1:0]       speed_q,
    output logic [CNT_W-1:0] stalls
);

    localparam logic [DIV_BITS-1:0] CC_ALL  = '1;
    localparam logic [DIV_BITS-1:0] CC_ONE  = {{(DIV_BITS-1){1'b0}}, 1'b1};
    localparam logic [DIV_BITS-1:0] CC_HALF = {1'b1, {(DIV_BITS-1){1'b0}}};
    localparam logic [DIV_BITS-2:0] Q7_HALF = {1'b1, {(DIV_BITS-2){1'b0}}};
    localparam logic [1:0]          MAX_Q   = MAX_SPEED[1:0];

    logic [DIV_BITS-1:0] r_cc;
    logic [1:0]          r_speed_q;
    logic                r_cpuck;
    logic                r_mlatch;
    logic                r_rst_q;
    logic [CNT_W-1:0]    r_stalls;

    logic                w_on;
    logic [1:0]          w_speed_clamp;
    logic [DIV_BITS-1:0] w_mask;
    logic [DIV_BITS-1:0] w_half;
    logic                w_ne_raw;
    logic                w_pe_raw;
    logic                w_contend;

    // r_rst_q keeps the cc=0 slot right after release quiet, so the first period is a whole one.
    assign w_on = power & ~r_rst_q;

    assign w_speed_clamp = (speed > MAX_Q) ? MAX_Q : speed;

    // Period P = 2^(DIV_BITS-s): mask is P-1, the rising slot sits at P/2.
    assign w_mask   = CC_ALL >> r_speed_q;
    assign w_half   = (w_mask >> 1) + CC_ONE;
    assign w_ne_raw = w_on & ((r_cc & w_mask) == '0);
    assign w_pe_raw = w_on & ((r_cc & w_mask) == w_half);

    assign w_contend = r_rst_q | (r_speed_q != 2'd0)
                     | ~(vcn & r_cpuck & r_mlatch & (mcont | ~ioula));

    assign ne7M0   = w_on & (r_cc[DIV_BITS-2:0] == '0);
    assign pe7M0   = w_on & (r_cc[DIV_BITS-2:0] == Q7_HALF);
    assign ne3M5   = w_on & (r_cc == '0);
    assign pe3M5   = w_on & (r_cc == CC_HALF);
    assign pcpu    = w_pe_raw & w_contend;
    assign ncpu    = w_ne_raw & w_contend;
    assign contend = w_contend;
    assign speed_q = r_speed_q;
    assign stalls  = r_stalls;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rst_q   <= 1'b1;
            r_cc      <= '0;
            r_speed_q <= 2'd0;
            r_cpuck   <= 1'b0;
            r_mlatch  <= 1'b1;
            r_stalls  <= '0;
        end else begin
            r_rst_q <= 1'b0;
            // Speed changes only at the period boundary, so no partial CPU period is emitted.
            if (power) begin
                r_cc <= r_cc + CC_ONE;
                if (r_cc == CC_ALL) begin
                    r_speed_q <= w_speed_clamp;
                end
            end
            if (r_speed_q == 2'd0) begin
                if (pcpu) begin
                    r_mlatch <= mreq & ioula;
                end
                if (ne7M0) begin
                    r_cpuck <= ~(r_cpuck & w_contend);
                end
            end
            if (cnt_clr) begin
                r_stalls <= '0;
            end else if (w_pe_raw & ~w_contend & ~(&r_stalls)) begin
                r_stalls <= r_stalls + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cpu_clken_gen.sv
// Bench for cpu_clken_gen: a cycle model predicts every output each clock; expected vectors are
// queued as stimulus is applied and popped against the DUT one clock phase later.
module tb_cpu_clken_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic power = 1'b1;
  logic [1:0] speed = 2'd0;
  logic vcn = 1'b0;
  logic mreq = 1'b1;
  logic ioula = 1'b1;
  logic mcont = 1'b0;
  logic cnt_clr = 1'b0;

  logic pe7M0, ne7M0, pe3M5, ne3M5, pcpu, ncpu, contend;
  logic [1:0] speed_q;
  logic [15:0] stalls;
  logic u4_pe7M0, u4_ne7M0, u4_pe3M5, u4_ne3M5, u4_pcpu, u4_ncpu, u4_contend;
  logic [1:0] u4_speed_q;
  logic [3:0] stalls4;

  cpu_clken_gen #(.DIV_BITS(4), .MAX_SPEED(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .power(power), .speed(speed), .vcn(vcn), .mreq(mreq),
    .ioula(ioula), .mcont(mcont), .cnt_clr(cnt_clr), .pe7M0(pe7M0), .ne7M0(ne7M0),
    .pe3M5(pe3M5), .ne3M5(ne3M5), .pcpu(pcpu), .ncpu(ncpu), .contend(contend),
    .speed_q(speed_q), .stalls(stalls)
  );

  cpu_clken_gen #(.DIV_BITS(4), .MAX_SPEED(3), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .power(power), .speed(speed), .vcn(vcn), .mreq(mreq),
    .ioula(ioula), .mcont(mcont), .cnt_clr(cnt_clr), .pe7M0(u4_pe7M0), .ne7M0(u4_ne7M0),
    .pe3M5(u4_pe3M5), .ne3M5(u4_ne3M5), .pcpu(u4_pcpu), .ncpu(u4_ncpu), .contend(u4_contend),
    .speed_q(u4_speed_q), .stalls(stalls4)
  );

  always #5 clock = ~clock;

  wire [37:0] got_vec = {pe7M0, ne7M0, pe3M5, ne3M5, pcpu, ncpu, contend, speed_q, stalls, stalls4,
                         u4_pe7M0, u4_ne7M0, u4_pe3M5, u4_ne3M5, u4_pcpu, u4_ncpu, u4_contend,
                         u4_speed_q};

  int tests_run = 0;
  int tests_failed = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_v;

  // Reference model state, advanced once per rising edge by tick().
  int m_cc = 0;
  logic [1:0] m_spq = 2'd0;
  logic m_rst = 1'b1;
  logic m_cpuck = 1'b0;
  logic m_mlatch = 1'b1;
  logic [15:0] m_stalls = 16'd0;
  logic [3:0] m_stalls4 = 4'd0;

  function automatic logic m_contend();
    return m_rst || (m_spq != 2'd0) || !(vcn && m_cpuck && m_mlatch && (mcont || !ioula));
  endfunction

  function automatic logic [37:0] model_vec();
    logic on, rne, rpe, ct;
    logic [6:0] en;
    int p;
    on  = !m_rst && power;
    p   = 16 >> m_spq;
    rne = on && (m_cc % p == 0);
    rpe = on && (m_cc % p == p / 2);
    ct  = m_contend();
    en  = {on && (m_cc % 8 == 4), on && (m_cc % 8 == 0), on && (m_cc == 8), on && (m_cc == 0),
           rpe && ct, rne && ct, ct};
    return {en, m_spq, m_stalls, m_stalls4, en, m_spq};
  endfunction

  task automatic tick();
    logic on, rpe, ct, pc, ne7;
    int p;
    @(posedge clock);
    on  = !m_rst && power;
    p   = 16 >> m_spq;
    rpe = on && (m_cc % p == p / 2);
    ct  = m_contend();
    pc  = rpe && ct;
    ne7 = on && (m_cc % 8 == 0);
    if (reset) begin
      m_rst = 1'b1; m_cc = 0; m_spq = 2'd0; m_cpuck = 1'b0; m_mlatch = 1'b1;
      m_stalls = 16'd0; m_stalls4 = 4'd0;
    end else begin
      m_rst = 1'b0;
      if (cnt_clr) begin
        m_stalls = 16'd0; m_stalls4 = 4'd0;
      end else if (rpe && !ct) begin
        if (m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
        if (m_stalls4 != 4'hF) m_stalls4 = m_stalls4 + 4'd1;
      end
      if (m_spq == 2'd0) begin
        if (pc) m_mlatch = mreq && ioula;
        if (ne7) m_cpuck = !(m_cpuck && ct);
      end
      if (power) begin
        if (m_cc == 15) m_spq = (speed > 2'd3) ? 2'd3 : speed;
        m_cc = (m_cc + 1) % 16;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b1; power = 1'b1; speed = 2'd0; vcn = 1'b0; mreq = 1'b1; ioula = 1'b1;
    mcont = 1'b0; cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if ({pe7M0, ne7M0, pe3M5, ne3M5, pcpu, ncpu} !== 6'b0 || stalls !== 16'd0 ||
          speed_q !== 2'd0 || contend !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_state: got en=%b stalls=%0d speed_q=%0d contend=%b, want en=0 stalls=0 speed_q=0 contend=1",
                 {pe7M0, ne7M0, pe3M5, ne3M5, pcpu, ncpu}, stalls, speed_q, contend);
      end
    end
    reset = 1'b0;
    exp_q.push_back(38'd16);
    first = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (ne3M5 === 1'b1) begin
        first = k;
        break;
      end
      tick();
    end
    exp_v = exp_q.pop_front();
    tests_run++;
    if (first !== int'(exp_v)) begin
      tests_failed++;
      $display("FAIL first_ne3M5: got clock %0d after release, want %0d", first, exp_v);
    end
  endtask

  task automatic test_speed0();
    speed = 2'd0; vcn = 1'b0; mcont = 1'b0; mreq = 1'b1; ioula = 1'b1;
    for (int c = 0; c < 48; c++) begin
      exp_q.push_back(model_vec());
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (got_vec !== exp_v) begin
        tests_failed++;
        $display("FAIL speed0 c=%0d: got %h want %h", c, got_vec, exp_v);
      end
      tests_run++;
      if (pcpu !== pe3M5 || (pcpu && ncpu)) begin
        tests_failed++;
        $display("FAIL speed0_pcpu_pe3M5 c=%0d: got pcpu=%b ncpu=%b, want pcpu=pe3M5=%b and not both", c, pcpu, ncpu, pe3M5);
      end
      tick();
    end
  endtask

  task automatic test_power();
    int gap;
    for (int k = 0; k < 32 && m_cc != 3; k++) tick();
    power = 1'b0;
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(model_vec());
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (got_vec !== exp_v || {pe7M0, ne7M0, pe3M5, ne3M5, pcpu, ncpu} !== 6'b0) begin
        tests_failed++;
        $display("FAIL power_off c=%0d: got %h want %h (enables 0)", c, got_vec, exp_v);
      end
      tick();
    end
    power = 1'b1;
    exp_q.push_back(38'd5);
    gap = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (pe3M5 === 1'b1 && gap < 0) gap = c;
      exp_v = model_vec();
      tests_run++;
      if (got_vec !== exp_v) begin
        tests_failed++;
        $display("FAIL power_resume c=%0d: got %h want %h", c, got_vec, exp_v);
      end
      tick();
    end
    exp_v = exp_q.pop_front();
    tests_run++;
    if (gap !== int'(exp_v)) begin
      tests_failed++;
      $display("FAIL power_phase: got pe3M5 %0d clocks after resume, want %0d", gap, exp_v);
    end
  endtask

  task automatic test_speed3();
    int last, npulse;
    for (int k = 0; k < 32 && m_cc != 5; k++) tick();
    speed = 2'd3;
    last = -1; npulse = 0;
    for (int c = 0; c < 40; c++) begin
      exp_q.push_back(model_vec());
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (got_vec !== exp_v) begin
        tests_failed++;
        $display("FAIL speed3 c=%0d: got %h want %h", c, got_vec, exp_v);
      end
      if (c == 10 || c == 11) begin
        tests_run++;
        if (speed_q !== ((c == 10) ? 2'd0 : 2'd3)) begin
          tests_failed++;
          $display("FAIL speed3_switch c=%0d: got speed_q=%0d want %0d", c, speed_q, (c == 10) ? 0 : 3);
        end
      end
      if (pcpu === 1'b1) begin
        if (c >= 11 && c < 27) npulse++;
        tests_run++;
        if (last >= 0 && c - last < 2) begin
          tests_failed++;
          $display("FAIL speed3_gap c=%0d: got gap %0d want >= 2", c, c - last);
        end
        last = c;
      end
      tick();
    end
    tests_run++;
    if (npulse !== 8) begin
      tests_failed++;
      $display("FAIL speed3_rate: got %0d pcpu in 16 clocks, want 8", npulse);
    end
  endtask

  task automatic wait_speed(input logic [1:0] s, input string name);
    int k;
    speed = s;
    for (k = 0; k < 40 && m_spq != s; k++) begin
      exp_q.push_back(model_vec());
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (got_vec !== exp_v) begin
        tests_failed++;
        $display("FAIL %s_wait k=%0d: got %h want %h", name, k, got_vec, exp_v);
      end
      tick();
    end
  endtask

  task automatic run_cycles(input int n, input string name, output int lost, output int nocont);
    lost = 0; nocont = 0;
    for (int c = 0; c < n; c++) begin
      exp_q.push_back(model_vec());
      #1;
      if (pe3M5 === 1'b1 && pcpu === 1'b0 && speed_q === 2'd0) lost++;
      if (contend === 1'b0) nocont++;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (got_vec !== exp_v) begin
        tests_failed++;
        $display("FAIL %s c=%0d: got %h want %h", name, c, got_vec, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    int lost, nocont;
    wait_speed(2'd0, "cont");
    vcn = 1'b0; mreq = 1'b1; ioula = 1'b1; mcont = 1'b1; cnt_clr = 1'b1;
    run_cycles(1, "cont_clr", lost, nocont);
    cnt_clr = 1'b0; vcn = 1'b1;
    run_cycles(64, "cont_on", lost, nocont);
    #1;
    tests_run++;
    if (stalls !== 16'(lost) || lost < 3) begin
      tests_failed++;
      $display("FAIL cont_stalls: got stalls=%0d lost=%0d, want stalls=lost and lost>=3", stalls, lost);
    end
    mreq = 1'b0;
    run_cycles(32, "cont_stuck", lost, nocont);
    vcn = 1'b0;
    run_cycles(16, "cont_release", lost, nocont);
    vcn = 1'b1;
    run_cycles(32, "cont_mreq0", lost, nocont);
    tests_run++;
    if (nocont !== 0) begin
      tests_failed++;
      $display("FAIL cont_mreq0: got %0d contended clocks, want 0", nocont);
    end
  endtask

  task automatic test_speed1();
    int lost, nocont, npulse;
    vcn = 1'b0; mreq = 1'b1; mcont = 1'b1;
    run_cycles(16, "sp1_prime", lost, nocont);
    vcn = 1'b1;
    wait_speed(2'd1, "sp1");
    npulse = 0; nocont = 0;
    for (int c = 0; c < 32; c++) begin
      exp_q.push_back(model_vec());
      #1;
      if (pcpu === 1'b1) npulse++;
      if (contend !== 1'b1) nocont++;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (got_vec !== exp_v) begin
        tests_failed++;
        $display("FAIL sp1 c=%0d: got %h want %h", c, got_vec, exp_v);
      end
      tick();
    end
    tests_run++;
    if (npulse !== 4 || nocont !== 0) begin
      tests_failed++;
      $display("FAIL sp1_turbo: got %0d pcpu, %0d contended clocks, want 4 and 0", npulse, nocont);
    end
  endtask

  task automatic test_saturate();
    int lost, nocont, k;
    wait_speed(2'd0, "sat");
    vcn = 1'b0; mreq = 1'b1; mcont = 1'b1;
    run_cycles(16, "sat_prime", lost, nocont);
    vcn = 1'b1;
    run_cycles(320, "sat_run", lost, nocont);
    #1;
    tests_run++;
    if (stalls4 !== 4'hF) begin
      tests_failed++;
      $display("FAIL sat_value: got stalls4=%0d want 15", stalls4);
    end
    for (k = 0; k < 32; k++) begin
      if (m_cc == 8 && !m_contend()) break;
      tick();
    end
    cnt_clr = 1'b1;
    exp_q.push_back(model_vec());
    #1;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (got_vec !== exp_v || pe3M5 !== 1'b1 || pcpu !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clr_slot: got %h pe3M5=%b pcpu=%b, want %h with a suppressed slot", got_vec, pe3M5, pcpu, exp_v);
    end
    tick();
    cnt_clr = 1'b0;
    #1;
    tests_run++;
    if (stalls4 !== 4'd0 || stalls !== 16'd0) begin
      tests_failed++;
      $display("FAIL sat_clr_priority: got stalls4=%0d stalls=%0d want 0 and 0", stalls4, stalls);
    end
  endtask

  initial begin
    test_reset();
    test_speed0();
    test_power();
    test_speed3();
    test_contention();
    test_speed1();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
